cache_dfp_arbiter: RTL and testbench

Arbitrates a single memory-side DFP port between the instruction cache and the data cache. Each cache controller issues line-sized reads and dirty-line writebacks and holds each request until it sees its response. The arbiter grants one requester at a time, holds the grant for the whole transaction and routes the response back. A dirty writeback and the allocate read that follows it stay paired, so a dcache miss is never split by an icache transaction.

---
 rtl/cache_dfp_arbiter_pkg.sv | 18 +
 rtl/cache_dfp_arbiter.sv | 136 +++++++++++++
 tb/tb_cache_dfp_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_dfp_arbiter_pkg.sv
// Shared types and default widths for the cache-to-memory DFP arbiter.
package cache_dfp_arbiter_pkg;

  localparam int DFP_ADDR_WIDTH = 32;
  localparam int DFP_LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_I = 2'b01,
    GNT_D = 2'b10
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/cache_dfp_arbiter.sv
// Shares one memory DFP port between the icache and dcache, keeping a dirty
// writeback and its allocate read together as a single grant.
module cache_dfp_arbiter
  import cache_dfp_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DFP_ADDR_WIDTH,
  parameter int LINE_WIDTH = DFP_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_dfp_read,
  input  logic                  icache_dfp_write,
  input  logic [ADDR_WIDTH-1:0] icache_dfp_addr,
  input  logic [LINE_WIDTH-1:0] icache_dfp_wdata,
  output logic [LINE_WIDTH-1:0] icache_dfp_rdata,
  output logic                  icache_dfp_resp,

  input  logic                  dcache_dfp_read,
  input  logic                  dcache_dfp_write,
  input  logic [ADDR_WIDTH-1:0] dcache_dfp_addr,
  input  logic [LINE_WIDTH-1:0] dcache_dfp_wdata,
  output logic [LINE_WIDTH-1:0] dcache_dfp_rdata,
  output logic                  dcache_dfp_resp,

  output logic                  dfp_read,
  output logic                  dfp_write,
  output logic [ADDR_WIDTH-1:0] dfp_addr,
  output logic [LINE_WIDTH-1:0] dfp_wdata,
  input  logic [LINE_WIDTH-1:0] dfp_rdata,
  input  logic                  dfp_resp,

  output arb_state_t            dbg_state
);

  // Handshake: a cache raises read or write (write wins if both) with a
  // stable address and holds it until its resp pulses; resp marks completion
  // and rdata is valid in that same cycle. Memory pulses dfp_resp once per op.

  arb_state_t state_q, state_d;
  logic       pair_q, pair_d;
  requester_t last_q, last_d;

  logic req_i, req_d;
  logic gnt_req;

  assign req_i     = icache_dfp_read | icache_dfp_write;
  assign req_d     = dcache_dfp_read | dcache_dfp_write;
  assign gnt_req   = dfp_read | dfp_write;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pair_q  <= 1'b0;
      last_q  <= REQ_I;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pair_d  = pair_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d = (last_q == REQ_I) ? GNT_D : GNT_I;
        end else if (req_i) begin
          state_d = GNT_I;
        end else if (req_d) begin
          state_d = GNT_D;
        end
      end
      GNT_I, GNT_D: begin
        if (dfp_resp) begin
          last_d = (state_q == GNT_I) ? REQ_I : REQ_D;
          if (dfp_write) begin
            // Keep the grant so the allocate read can follow with no bubble.
            pair_d = 1'b1;
          end else begin
            pair_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (pair_q) begin
          pair_d = 1'b0;
          if (!gnt_req) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pair_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    dfp_read         = 1'b0;
    dfp_write        = 1'b0;
    dfp_addr         = '0;
    dfp_wdata        = '0;
    icache_dfp_resp  = 1'b0;
    dcache_dfp_resp  = 1'b0;
    icache_dfp_rdata = dfp_rdata;
    dcache_dfp_rdata = dfp_rdata;
    case (state_q)
      GNT_I: begin
        dfp_write       = icache_dfp_write;
        dfp_read        = icache_dfp_read & ~icache_dfp_write;
        dfp_addr        = icache_dfp_addr;
        dfp_wdata       = icache_dfp_wdata;
        icache_dfp_resp = dfp_resp;
      end
      GNT_D: begin
        dfp_write       = dcache_dfp_write;
        dfp_read        = dcache_dfp_read & ~dcache_dfp_write;
        dfp_addr        = dcache_dfp_addr;
        dfp_wdata       = dcache_dfp_wdata;
        dcache_dfp_resp = dfp_resp;
      end
      default: ;
    endcase
  end

  // Within one granted transaction the requester must not change op or address.
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    ((state_q != IDLE) && (state_q == $past(state_q)) && !pair_q &&
     !$past(pair_q) && !$past(dfp_resp))
    |-> ($stable(dfp_addr) && $stable(dfp_read) && $stable(dfp_write)));

endmodule

// File: tb/tb_cache_dfp_arbiter.sv
// Directed and randomized bench for cache_dfp_arbiter with a turn-based
// reference model of the expected memory transaction order.
module tb_cache_dfp_arbiter;
  import cache_dfp_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_dfp_read, icache_dfp_write;
  logic [AW-1:0] icache_dfp_addr;
  logic [LW-1:0] icache_dfp_wdata, icache_dfp_rdata;
  logic          icache_dfp_resp;
  logic          dcache_dfp_read, dcache_dfp_write;
  logic [AW-1:0] dcache_dfp_addr;
  logic [LW-1:0] dcache_dfp_wdata, dcache_dfp_rdata;
  logic          dcache_dfp_resp;
  logic          dfp_read, dfp_write;
  logic [AW-1:0] dfp_addr;
  logic [LW-1:0] dfp_wdata, dfp_rdata;
  logic          dfp_resp;
  arb_state_t    dbg_state;

  cache_dfp_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .icache_dfp_read(icache_dfp_read), .icache_dfp_write(icache_dfp_write),
    .icache_dfp_addr(icache_dfp_addr), .icache_dfp_wdata(icache_dfp_wdata),
    .icache_dfp_rdata(icache_dfp_rdata), .icache_dfp_resp(icache_dfp_resp),
    .dcache_dfp_read(dcache_dfp_read), .dcache_dfp_write(dcache_dfp_write),
    .dcache_dfp_addr(dcache_dfp_addr), .dcache_dfp_wdata(dcache_dfp_wdata),
    .dcache_dfp_rdata(dcache_dfp_rdata), .dcache_dfp_resp(dcache_dfp_resp),
    .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_addr(dfp_addr),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
  } op_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    int            src;
    int            seen;
    int            resp;
    int            start;
  } log_t;

  op_t           iq[$], dq[$];
  log_t          mlog[$];
  logic [AW:0]   exp_q[$];
  int            tests, fails, cyc;
  int            i_start, d_start, cnt, lat_cfg, src_now, rel_cyc;
  logic          i_act, d_act, i_done, d_done, busy, resp_now, spurious;
  logic [LW-1:0] cap_i_rdata;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rdata_fn(input logic [AW-1:0] a);
    logic [31:0] w;
    w = (a == 32'h0000_1040) ? 32'hA5A5_A5A5 : (a ^ 32'h5A5A_0F0F);
    return {8{w}};
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Caches hold the head of their queue until its resp was seen last cycle.
  task automatic drive_caches();
    op_t t;
    if (i_done && iq.size() > 0) begin t = iq.pop_front(); i_act = 1'b0; end
    if (d_done && dq.size() > 0) begin t = dq.pop_front(); d_act = 1'b0; end
    i_done = 1'b0;
    d_done = 1'b0;
    if (iq.size() > 0 && !i_act) begin i_act = 1'b1; i_start = cyc; end
    if (dq.size() > 0 && !d_act) begin d_act = 1'b1; d_start = cyc; end
    icache_dfp_read = 1'b0; icache_dfp_write = 1'b0; icache_dfp_addr = '0; icache_dfp_wdata = '0;
    dcache_dfp_read = 1'b0; dcache_dfp_write = 1'b0; dcache_dfp_addr = '0; dcache_dfp_wdata = '0;
    if (iq.size() > 0) begin
      icache_dfp_read = ~iq[0].wr; icache_dfp_write = iq[0].wr;
      icache_dfp_addr = iq[0].addr; icache_dfp_wdata = {8{iq[0].addr}};
    end
    if (dq.size() > 0) begin
      dcache_dfp_read = ~dq[0].wr; dcache_dfp_write = dq[0].wr;
      dcache_dfp_addr = dq[0].addr; dcache_dfp_wdata = {8{~dq[0].addr}};
    end
  endtask

  // Memory: latches a new op when first visible, responds after cnt cycles.
  task automatic mem_step();
    log_t e;
    resp_now = 1'b0;
    src_now  = 2;
    dfp_resp = 1'b0;
    if (rst) begin
      busy = 1'b0;
    end else if (spurious) begin
      spurious = 1'b0;
      dfp_resp = 1'b1;
      dfp_rdata = {8{$urandom}};
    end else if (dfp_read || dfp_write) begin
      if (!busy) begin
        busy = 1'b1;
        cnt  = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
        e.wr = dfp_write; e.addr = dfp_addr; e.seen = cyc; e.resp = -1;
        if (iq.size() > 0 && iq[0].addr == dfp_addr && iq[0].wr == dfp_write) begin
          e.src = 0; e.start = i_start;
        end else begin
          e.src = 1; e.start = d_start;
        end
        mlog.push_back(e);
      end
      cnt--;
      if (cnt == 0) begin
        busy      = 1'b0;
        dfp_resp  = 1'b1;
        resp_now  = 1'b1;
        src_now   = mlog[mlog.size()-1].src;
        dfp_rdata = rdata_fn(dfp_addr);
        mlog[mlog.size()-1].resp = cyc;
      end
    end
  endtask

  task automatic check_step();
    chk("icache_resp", LW'(icache_dfp_resp), LW'(resp_now && src_now == 0));
    chk("dcache_resp", LW'(dcache_dfp_resp), LW'(resp_now && src_now == 1));
    if (resp_now) begin
      chk("icache_rdata", icache_dfp_rdata, dfp_rdata);
      chk("dcache_rdata", dcache_dfp_rdata, dfp_rdata);
      if (src_now == 0) cap_i_rdata = icache_dfp_rdata;
    end
    i_done = resp_now && src_now == 0;
    d_done = resp_now && src_now == 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1 drive_caches();
    #1 mem_step();
    #1 check_step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iq.delete(); dq.delete();
    i_act = 1'b0; d_act = 1'b0; i_done = 1'b0; d_done = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    mlog.delete();
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || busy) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", LW'(iq.size() + dq.size()), LW'(0));
    cycle();
    cycle();
  endtask

  // Grants alternate starting with the dcache; a write plus the op that
  // follows it from the same cache is one turn.
  task automatic build_expected();
    op_t a[$], b[$], o;
    int turn;
    a = iq; b = dq; turn = 1;
    exp_q.delete();
    while (a.size() > 0 || b.size() > 0) begin
      if ((turn == 1 && b.size() > 0) || a.size() == 0) begin
        o = b.pop_front(); exp_q.push_back({o.wr, o.addr});
        if (o.wr && b.size() > 0) begin o = b.pop_front(); exp_q.push_back({o.wr, o.addr}); end
        turn = 0;
      end else begin
        o = a.pop_front(); exp_q.push_back({o.wr, o.addr});
        if (o.wr && a.size() > 0) begin o = a.pop_front(); exp_q.push_back({o.wr, o.addr}); end
        turn = 1;
      end
    end
  endtask

  task automatic check_log(input string tag, input bit timing);
    int exp_seen;
    chk({tag, "_len"}, LW'(mlog.size()), LW'(exp_q.size()));
    for (int i = 0; i < mlog.size() && i < exp_q.size(); i++) begin
      chk({tag, "_op"}, LW'({mlog[i].wr, mlog[i].addr}), LW'(exp_q[i]));
      if (timing) begin
        if (i == 0) exp_seen = mlog[i].start + 1;
        else if (mlog[i-1].wr && mlog[i-1].src == mlog[i].src &&
                 mlog[i].start == mlog[i-1].resp + 1) exp_seen = mlog[i].start;
        else if (mlog[i-1].wr) exp_seen = imax(mlog[i].start + 1, mlog[i-1].resp + 3);
        else exp_seen = imax(mlog[i].start + 1, mlog[i-1].resp + 2);
        chk({tag, "_seen_cycle"}, LW'(mlog[i].seen), LW'(exp_seen));
      end
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; busy = 1'b0; spurious = 1'b0; lat_cfg = 3;
    cnt = 0; src_now = 2; resp_now = 1'b0; i_start = 0; d_start = 0;
    cap_i_rdata = '0;
    dfp_resp = 1'b0;
    dfp_rdata = {8{32'h1357_9BDF}};
    do_reset();

    // Reset state
    chk("rst_state", LW'(dbg_state), LW'(IDLE));
    chk("rst_dfp_read", LW'(dfp_read), LW'(0));
    chk("rst_dfp_write", LW'(dfp_write), LW'(0));
    chk("rst_dfp_addr", LW'(dfp_addr), LW'(0));
    chk("rst_icache_rdata", icache_dfp_rdata, dfp_rdata);
    chk("rst_dcache_rdata", dcache_dfp_rdata, dfp_rdata);

    // Stray memory resp while idle
    spurious = 1'b1;
    cycle();
    cycle();
    chk("spur_state", LW'(dbg_state), LW'(IDLE));
    chk("spur_dfp_read", LW'(dfp_read), LW'(0));

    // Single icache read, 5-cycle memory
    do_reset();
    lat_cfg = 5;
    iq.push_back('{wr: 1'b0, addr: 32'h0000_1040});
    build_expected();
    run_until_done(200);
    check_log("single_read", 1'b1);
    chk("single_read_rdata", cap_i_rdata, {32{8'hA5}});

    // Tie after reset goes to the dcache
    do_reset();
    lat_cfg = 2;
    iq.push_back('{wr: 1'b0, addr: 32'h100});
    dq.push_back('{wr: 1'b0, addr: 32'h200});
    build_expected();
    run_until_done(200);
    check_log("tie", 1'b1);

    // Dirty miss pairing
    do_reset();
    lat_cfg = 3;
    dq.push_back('{wr: 1'b1, addr: 32'h300});
    dq.push_back('{wr: 1'b0, addr: 32'h500});
    iq.push_back('{wr: 1'b0, addr: 32'h400});
    build_expected();
    run_until_done(200);
    check_log("pair", 1'b1);

    // Writeback with no allocate read releases the grant
    do_reset();
    dq.push_back('{wr: 1'b1, addr: 32'h300});
    iq.push_back('{wr: 1'b0, addr: 32'h400});
    build_expected();
    run_until_done(200);
    check_log("pair_release", 1'b1);

    // Round-robin with back-to-back reads
    do_reset();
    for (int k = 0; k < 4; k++) begin
      dq.push_back('{wr: 1'b0, addr: 32'h1000 + 32'(k) * 32'h40});
      iq.push_back('{wr: 1'b0, addr: 32'h2000 + 32'(k) * 32'h40});
    end
    build_expected();
    run_until_done(400);
    check_log("round_robin", 1'b1);

    // Reset during an icache grant; dcache must win after release
    do_reset();
    lat_cfg = 8;
    dq.push_back('{wr: 1'b0, addr: 32'h600});
    dq.push_back('{wr: 1'b0, addr: 32'h700});
    iq.push_back('{wr: 1'b0, addr: 32'h800});
    for (int n = 0; n < 100 && mlog.size() < 2; n++) cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("midrst_dfp_read", LW'(dfp_read), LW'(0));
    chk("midrst_dfp_addr", LW'(dfp_addr), LW'(0));
    chk("midrst_state", LW'(dbg_state), LW'(IDLE));
    rst = 1'b0;
    rel_cyc = cyc + 1;
    run_until_done(400);
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h600});
    exp_q.push_back({1'b0, 32'h800});
    exp_q.push_back({1'b0, 32'h700});
    exp_q.push_back({1'b0, 32'h800});
    check_log("midrst", 1'b0);
    if (mlog.size() > 2) chk("midrst_regrant_cycle", LW'(mlog[2].seen), LW'(rel_cyc));

    // Randomized jobs with random memory latency
    for (int r = 0; r < 3; r++) begin
      do_reset();
      lat_cfg = 0;
      for (int k = 0; k < 10; k++) begin
        if ($urandom_range(0, 3) == 0) dq.push_back('{wr: 1'b1, addr: 32'h8000_0000 + 32'(2*k) * 32'h40});
        dq.push_back('{wr: 1'b0, addr: 32'h8000_0000 + 32'(2*k+1) * 32'h40});
        if ($urandom_range(0, 5) == 0) iq.push_back('{wr: 1'b1, addr: 32'h0001_0000 + 32'(2*k) * 32'h40});
        if ($urandom_range(0, 3) != 0) iq.push_back('{wr: 1'b0, addr: 32'h0001_0000 + 32'(2*k+1) * 32'h40});
      end
      build_expected();
      run_until_done(2000);
      check_log("random", 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
